buffer_stage: RTL and testbench

Data buffer that sits between the input source and the downstream consumer, under control of the `machine` state controller. It consumes the controller's registered `state` output, stores words in a small first-in first-out buffer while filling, and drains them while in the output state. It generates the one-cycle `changes` pulse that advances the controller, closing the control loop.

---
 rtl/buffer_stage.sv | 143 ++++++++++++++
 tb/tb_buffer_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/buffer_stage.sv
// FIFO data buffer driven by the controller state: fills in IN/BUFF, drains first-word-fall-through in OUT.
// Zero-cycle head visibility; in_ready drops at full, out_valid drops at empty, both held low on err or reset.
module buffer_stage #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int IDLE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               state,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     changes,
  output logic                     err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int IDLE_W = $clog2(IDLE_MAX + 1);

  localparam logic [1:0] ST_IN   = 2'b00;
  localparam logic [1:0] ST_BUFF = 2'b01;
  localparam logic [1:0] ST_OUT  = 2'b10;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              changes_q, changes_d;
  logic              locked_q, locked_d;
  logic [1:0]        lock_state_q, lock_state_d;
  logic              err_q, err_d;

  logic is_full;
  logic is_empty;
  logic wr_en;
  logic rd_en;
  logic pulse_cond;
  logic fire;

  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);

  // Fill and drain are gated by disjoint states, so wr_en and rd_en never coincide.
  assign in_ready  = reset && !err_q && (state == ST_IN || state == ST_BUFF) && !is_full;
  assign out_valid = reset && !err_q && (state == ST_OUT) && !is_empty;
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  assign count   = count_q;
  assign changes = changes_q;
  assign err     = err_q;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = in_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d  = count_q + CNT_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    pulse_cond = 1'b0;
    case (state)
      ST_IN:   pulse_cond = is_full;
      ST_BUFF: pulse_cond = is_full || (idle_q == IDLE_W'(IDLE_MAX));
      ST_OUT:  pulse_cond = is_empty;
      default: pulse_cond = 1'b0;
    endcase
    fire = pulse_cond && !locked_q && !err_q;
  end

  always_comb begin
    idle_d = idle_q;
    if (wr_en || state != ST_BUFF || is_empty) begin
      idle_d = '0;
    end else if (idle_q != IDLE_W'(IDLE_MAX)) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  // Lockout spans the controller's latency until it shows a state other than the one that pulsed.
  always_comb begin
    changes_d    = fire;
    locked_d     = locked_q;
    lock_state_d = lock_state_q;
    if (fire) begin
      locked_d     = 1'b1;
      lock_state_d = state;
    end else if (locked_q && state != lock_state_q) begin
      locked_d = 1'b0;
    end
    err_d = err_q || (state == 2'b11);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      idle_q       <= '0;
      changes_q    <= 1'b0;
      locked_q     <= 1'b0;
      lock_state_q <= 2'b00;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      idle_q       <= idle_d;
      changes_q    <= changes_d;
      locked_q     <= locked_d;
      lock_state_q <= lock_state_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_buffer_stage.sv
// Scoreboard bench for buffer_stage: directed phases then a closed loop with a behavioural controller.
module tb_buffer_stage;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int IM = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   state = 2'b00;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [2:0]   count;
  logic         changes;
  logic         err;

  buffer_stage #(.WIDTH(W), .DEPTH(D), .IDLE_MAX(IM)) dut (
    .clk(clk), .reset(reset), .state(state),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .changes(changes), .err(err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         m_count = 0;
  int         m_idle = 0;
  bit         m_err = 0;
  bit         m_locked = 0;
  bit         m_changes = 0;
  logic [1:0] m_lock_state = 2'b00;
  logic [W-1:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit exp_in_ready();
    return reset && !m_err && (state == 2'd0 || state == 2'd1) && (m_count < D);
  endfunction

  function automatic bit exp_out_valid();
    return reset && !m_err && (state == 2'd2) && (m_count > 0);
  endfunction

  // Reference model: occupancy as an integer, contents as a queue, pulse rules from the state table.
  always @(posedge clk) begin
    bit wr, rd, cond;
    wr = in_valid && exp_in_ready();
    rd = out_ready && exp_out_valid();
    if (!reset) begin
      m_count = 0; m_idle = 0; m_err = 0; m_locked = 0; m_changes = 0;
      m_lock_state = 2'b00;
      sb.delete();
    end else begin
      cond = 0;
      if (!m_err && !m_locked) begin
        case (state)
          2'd0:    cond = (m_count == D);
          2'd1:    cond = (m_count == D) || (m_idle == IM);
          2'd2:    cond = (m_count == 0);
          default: cond = 0;
        endcase
      end
      if (wr || state != 2'd1 || m_count == 0) m_idle = 0;
      else if (m_idle < IM) m_idle++;
      if (cond) begin
        m_locked = 1; m_lock_state = state;
      end else if (m_locked && state != m_lock_state) begin
        m_locked = 0;
      end
      m_changes = cond;
      if (state == 2'd3) m_err = 1;
      if (wr) begin m_count++; sb.push_back(in_data); end
      if (rd) m_count--;
    end
  end

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(exp_in_ready()));
    check("out_valid", 32'(out_valid), 32'(exp_out_valid()));
    check("count", 32'(count), 32'(m_count));
    check("changes", 32'(changes), 32'(m_changes));
    check("err", 32'(err), 32'(m_err));
    if (!exp_out_valid()) check("out_data_idle", 32'(out_data), 32'd0);
  end

  // Monitor: consumes one expected word per downstream handshake.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow at %0t: got word %0h expected no word", $time, out_data);
      end else begin
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pend;
    logic [1:0] nxt;
    int pct;
    nxt = 2'b00;
    pend = 0;

    reset = 1'b0; in_valid = 1'b1; in_data = 8'h5A; state = 2'b00;
    repeat (3) tick();
    reset = 1'b1; in_valid = 1'b0;
    tick();

    for (int rep = 0; rep < 3; rep++) begin
      state = 2'b00;
      for (int i = 0; i < D; i++) begin
        in_valid = 1'b1;
        in_data  = (rep == 0) ? W'(8'hA0 + i) : W'($urandom);
        tick();
      end
      in_valid = 1'b0;
      repeat (4) tick();
      state = 2'b10; out_ready = 1'b1;
      repeat (7) tick();
      out_ready = 1'b0;
    end

    state = 2'b01;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = W'($urandom); tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    in_valid = 1'b1; in_data = W'($urandom); tick();
    in_valid = 1'b0;
    repeat (12) tick();

    state = 2'b10; out_ready = 1'b1; tick();
    out_ready = 1'b0; state = 2'b11; tick();
    state = 2'b10; out_ready = 1'b1;
    repeat (4) tick();
    reset = 1'b0; tick();
    reset = 1'b1; state = 2'b00; out_ready = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = W'($urandom); tick();
    end
    in_valid = 1'b0; state = 2'b10;
    tick();
    reset = 1'b0; tick();
    reset = 1'b1;
    repeat (3) tick();

    state = 2'b00;
    for (int seg = 0; seg < 4; seg++) begin
      pct = (seg == 0) ? 80 : (seg == 1) ? 30 : (seg == 2) ? 8 : 60;
      for (int c = 0; c < 200; c++) begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) state = nxt;
        end else if (m_changes) begin
          nxt  = (state == 2'b01) ? 2'b10 : 2'b01;
          pend = 2;
        end
        in_valid  = ($urandom_range(99) < pct);
        in_data   = W'($urandom);
        out_ready = ($urandom_range(99) < 70);
        tick();
      end
    end

    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
